// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector.
//   MODE_*      : 2-bit per-channel edge selection codes
//   filt_cnt_w  : width of the per-channel stability filter counter
package edge_det_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Counter must hold values up to FILTER_LEN-1; sized as clog2(FILTER_LEN+1).
  function automatic int unsigned filt_cnt_w(input int unsigned filter_len);
    return $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, stability filter, edge detect,
// sticky flag and saturating event counter.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   sig_i         : raw asynchronous input
//   mode_i        : edge selection (off / rise / fall / both)
//   flag_clr_i    : level-sensitive sticky-flag clear
//   cnt_clr_i     : event counter clear
//   pulse_o       : one-cycle pulse per qualifying edge
//   flag_o        : sticky edge flag
//   level_o       : debounced level
//   count_o       : saturating event count
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned CNT_W       = 8,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_i,
  input  logic [1:0]       mode_i,
  input  logic             flag_clr_i,
  input  logic             cnt_clr_i,
  output logic             pulse_o,
  output logic             flag_o,
  output logic             level_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned FCW = filt_cnt_w(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FCW-1:0]         fcnt_q, fcnt_d;
  logic                   level_q, level_d;
  logic                   level_dly_q;
  logic                   pulse_q, pulse_d;
  logic                   flag_q, flag_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic toggled;
  logic qual;

  // Next-state logic for synchroniser, filter, detect, flag and counter.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
    level_d = level_q;
    fcnt_d  = '0;
    qual    = 1'b0;
    flag_d  = flag_q;
    count_d = count_q;

    // Filter: accept the new level on the FILTER_LEN-th consecutive mismatch.
    if (sync_q[SYNC_STAGES-1] != level_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        level_d = ~level_q;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end

    // The accepted toggle is seen one cycle later via the delayed level.
    toggled = level_q ^ level_dly_q;
    case (mode_i)
      MODE_OFF:  qual = 1'b0;
      MODE_RISE: qual = toggled & level_q;
      MODE_FALL: qual = toggled & ~level_q;
      MODE_BOTH: qual = toggled;
      default:   qual = 1'b0;
    endcase

    pulse_d = qual;

    // Set has priority over clear.
    if (qual) begin
      flag_d = 1'b1;
    end else if (flag_clr_i) begin
      flag_d = 1'b0;
    end

    // Clear coinciding with an event leaves a count of one.
    if (cnt_clr_i) begin
      count_d = qual ? CNT_W'(1) : '0;
    end else if (qual && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= {SYNC_STAGES{INIT_LEVEL}};
      fcnt_q      <= '0;
      level_q     <= INIT_LEVEL;
      level_dly_q <= INIT_LEVEL;
      pulse_q     <= 1'b0;
      flag_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      sync_q      <= sync_d;
      fcnt_q      <= fcnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pulse_q     <= pulse_d;
      flag_q      <= flag_d;
      count_q     <= count_d;
    end
  end

  assign pulse_o = pulse_q;
  assign flag_o  = flag_q;
  assign level_o = level_q;
  assign count_o = count_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Parametrised multi-channel edge detector: WIDTH independent channels,
// each synchronised, deglitched and edge-checked per its mode.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   signal_in    : raw asynchronous inputs
//   mode         : per-channel mode, channel i at [2i+1:2i]
//   flag_clr     : per-channel sticky-flag clear
//   cnt_clr      : clears all event counters
//   edge_pulse   : one-cycle pulse per qualifying edge
//   edge_flag    : sticky edge flags
//   filt_level   : debounced levels
//   event_count  : per-channel counters, channel i at [CNT_W*(i+1)-1:CNT_W*i]
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned CNT_W       = 8,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       signal_in,
  input  logic [2*WIDTH-1:0]     mode,
  input  logic [WIDTH-1:0]       flag_clr,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       edge_pulse,
  output logic [WIDTH-1:0]       edge_flag,
  output logic [WIDTH-1:0]       filt_level,
  output logic [WIDTH*CNT_W-1:0] event_count
);

  // One channel per input bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .CNT_W       (CNT_W),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_i      (signal_in[i]),
      .mode_i     (mode[2*i +: 2]),
      .flag_clr_i (flag_clr[i]),
      .cnt_clr_i  (cnt_clr),
      .pulse_o    (edge_pulse[i]),
      .flag_o     (edge_flag[i]),
      .level_o    (filt_level[i]),
      .count_o    (event_count[CNT_W*i +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised plus directed bench for multi_edge_detector against a
// cycle-level behavioural model. Two instances share all inputs: one with
// 8-bit counters and one with 2-bit counters for saturation.
module tb_multi_edge_detector;

  localparam int W   = 4;
  localparam int SS  = 2;
  localparam int FL  = 3;
  localparam int CW  = 8;
  localparam int CWS = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    signal_in;
  logic [2*W-1:0]  mode;
  logic [W-1:0]    flag_clr;
  logic            cnt_clr;
  logic [W-1:0]    edge_pulse, edge_flag, filt_level;
  logic [W*CW-1:0] event_count;
  logic [W-1:0]    edge_pulse_s, edge_flag_s, filt_level_s;
  logic [W*CWS-1:0] event_count_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL), .CNT_W(CW), .INIT_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .mode(mode), .flag_clr(flag_clr),
    .cnt_clr(cnt_clr), .edge_pulse(edge_pulse), .edge_flag(edge_flag),
    .filt_level(filt_level), .event_count(event_count)
  );

  multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL), .CNT_W(CWS), .INIT_LEVEL(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .mode(mode), .flag_clr(flag_clr),
    .cnt_clr(cnt_clr), .edge_pulse(edge_pulse_s), .edge_flag(edge_flag_s),
    .filt_level(filt_level_s), .event_count(event_count_s)
  );

  // Reference model: input history, accepted level, run length of
  // disagreement, and whether the level was accepted on the last edge.
  bit hist [W][SS];
  bit lvl  [W];
  int run  [W];
  bit tog  [W];
  bit pls  [W];
  bit flg  [W];
  int cnt  [W];
  int cnts [W];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < W; c++) begin
      for (int k = 0; k < SS; k++) hist[c][k] = 1'b0;
      lvl[c] = 1'b0; run[c] = 0; tog[c] = 1'b0;
      pls[c] = 1'b0; flg[c] = 1'b0; cnt[c] = 0; cnts[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < W; c++) begin
      logic [1:0] m;
      bit ev;
      m  = mode[2*c +: 2];
      // Rise = new level 1 and mode bit0; fall = new level 0 and mode bit1.
      ev = tog[c] && ((lvl[c] && m[0]) || (!lvl[c] && m[1]));
      pls[c] = ev;
      flg[c] = ev ? 1'b1 : (flag_clr[c] ? 1'b0 : flg[c]);
      if (cnt_clr) begin
        cnt[c]  = ev ? 1 : 0;
        cnts[c] = ev ? 1 : 0;
      end else if (ev) begin
        cnt[c]  = (cnt[c]  + 1 > (1 << CW)  - 1) ? (1 << CW)  - 1 : cnt[c]  + 1;
        cnts[c] = (cnts[c] + 1 > (1 << CWS) - 1) ? (1 << CWS) - 1 : cnts[c] + 1;
      end
      tog[c] = 1'b0;
      if (hist[c][SS-1] != lvl[c]) begin
        run[c]++;
        if (run[c] == FL) begin
          lvl[c] = ~lvl[c];
          run[c] = 0;
          tog[c] = 1'b1;
        end
      end else begin
        run[c] = 0;
      end
      for (int k = SS-1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = signal_in[c];
    end
  endfunction

  task automatic compare_all();
    logic [W-1:0]     ep, ef, el;
    logic [W*CW-1:0]  ec;
    logic [W*CWS-1:0] ecs;
    for (int c = 0; c < W; c++) begin
      ep[c] = pls[c]; ef[c] = flg[c]; el[c] = lvl[c];
      ec[c*CW +: CW]    = CW'(cnt[c]);
      ecs[c*CWS +: CWS] = CWS'(cnts[c]);
    end
    chk("filt_level",  64'(filt_level),    64'(el));
    chk("edge_pulse",  64'(edge_pulse),    64'(ep));
    chk("edge_flag",   64'(edge_flag),     64'(ef));
    chk("event_count", 64'(event_count),   64'(ec));
    chk("count_small", 64'(event_count_s), 64'(ecs));
  endtask

  // One clock: model follows the DUT edge, compare just after it.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  function automatic logic [CW-1:0] cnt_of(input int c);
    logic [W*CW-1:0] v;
    v = event_count;
    return v[c*CW +: CW];
  endfunction

  function automatic logic [CWS-1:0] cnts_of(input int c);
    logic [W*CWS-1:0] v;
    v = event_count_s;
    return v[c*CWS +: CWS];
  endfunction

  initial begin
    signal_in = 4'hF; mode = 8'hFF; flag_clr = '0; cnt_clr = 1'b0;
    rst_n = 1'b1;
    #2;
    async_reset();
    // Held in reset with inputs high: everything stays zero.
    steps(3);
    chk("rst_hold_level", 64'(filt_level), 64'h0);

    // Release: level accepted after edge 5, rise pulses on edge 6.
    rst_n = 1'b1;
    steps(4);
    chk("rel_level_e4", 64'(filt_level), 64'h0);
    step();
    chk("rel_level_e5", 64'(filt_level), 64'hF);
    chk("rel_pulse_e5", 64'(edge_pulse), 64'h0);
    step();
    chk("rel_pulse_e6", 64'(edge_pulse), 64'hF);
    step();
    chk("rel_pulse_e7", 64'(edge_pulse), 64'h0);

    // Latency: fall-only on channel 0.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    mode[1:0] = 2'b10;
    signal_in[0] = 1'b0;
    steps(5);
    chk("lat_pulse_e5", 64'(edge_pulse[0]), 64'h0);
    step();
    chk("lat_pulse_e6", 64'(edge_pulse[0]), 64'h1);
    chk("lat_count_e6", 64'(cnt_of(0)), 64'h1);
    step();
    chk("lat_pulse_e7", 64'(edge_pulse[0]), 64'h0);
    mode[1:0] = 2'b11;

    // Glitch on channel 1: 2-cycle high is rejected, 3-cycle high accepted.
    signal_in[1] = 1'b0; steps(8);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    signal_in[1] = 1'b1; steps(2);
    signal_in[1] = 1'b0; steps(10);
    chk("glitch2_level", 64'(filt_level[1]), 64'h0);
    chk("glitch2_count", 64'(cnt_of(1)), 64'h0);
    signal_in[1] = 1'b1; steps(3);
    signal_in[1] = 1'b0; steps(12);
    chk("glitch3_count", 64'(cnt_of(1)), 64'h2);

    // Modes on channel 2 (currently high): 3 fall/rise pairs per mode.
    for (int m = 0; m < 4; m++) begin
      logic [CW-1:0] want;
      mode[5:4] = 2'(m);
      cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
      for (int p = 0; p < 3; p++) begin
        signal_in[2] = 1'b0; steps(6);
        signal_in[2] = 1'b1; steps(6);
      end
      steps(2);
      want = (m == 0) ? CW'(0) : (m == 3) ? CW'(6) : CW'(3);
      chk("mode_count", 64'(cnt_of(2)), 64'(want));
    end
    chk("sat_count_small", 64'(cnts_of(2)), 64'h3);

    // Counter clear and flag clear coinciding with an event on channel 3.
    signal_in[3] = 1'b0;
    steps(5);
    cnt_clr = 1'b1; flag_clr[3] = 1'b1;
    step();
    chk("clr_evt_count",  64'(cnt_of(3)), 64'h1);
    chk("clr_evt_counts", 64'(cnts_of(3)), 64'h1);
    chk("clr_evt_flag",   64'(edge_flag[3]), 64'h1);
    cnt_clr = 1'b0;
    step();
    chk("clr_flag_next", 64'(edge_flag[3]), 64'h0);
    flag_clr[3] = 1'b0;

    // Reset two cycles into filtering of a channel-0 rise.
    steps(4);
    signal_in = 4'b0001;
    steps(4);
    async_reset();
    chk("mid_rst_level", 64'(filt_level), 64'h0);
    step();
    rst_n = 1'b1;
    steps(5);
    chk("post_rst_nopulse", 64'(edge_pulse), 64'h0);
    step();
    chk("post_rst_pulse", 64'(edge_pulse), 64'h1);

    // Randomised traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 5) == 0) signal_in[c] = ~signal_in[c];
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      flag_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
      cnt_clr  = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 999) == 0) begin
        async_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel edge detector, the successor to the single-channel falling-edge detector. Each of WIDTH asynchronous inputs is synchronised, deglitched by a stability filter and checked for rising, falling or both edges as chosen by a per-channel mode. Every channel produces a one-cycle pulse, a sticky flag with clear, and a saturating event counter. The block sits between raw external/slow-domain signals and interrupt or status logic.

## Interface
- WIDTH, 4: number of channels (≥1)
- SYNC_STAGES, 2: synchroniser depth (≥2)
- FILTER_LEN, 3: consecutive cycles a new level must be stable before acceptance (≥1)
- CNT_W, 8: event counter width per channel (≥1)
- INIT_LEVEL, 0: reset value of synchroniser and filtered level, all channels
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- signal_in  input  WIDTH  raw asynchronous inputs
- mode  input  2*WIDTH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- flag_clr  input  WIDTH  per-channel sticky-flag clear, level-sensitive
- cnt_clr  input  1  clears all event counters
- edge_pulse  output  WIDTH  one-cycle pulse per qualifying edge
- edge_flag  output  WIDTH  sticky edge flags
- filt_level  output  WIDTH  debounced level
- event_count  output  WIDTH*CNT_W  per-channel counters, channel i at [CNT_W*(i+1)-1:CNT_W*i]

## Operation
- Reset (rst_n low, asynchronous): synchroniser and filt_level = INIT_LEVEL; filter counters, edge_pulse, edge_flag, event_count = 0.
- Synchroniser: SYNC_STAGES flops per channel. Last stage is sync.
- Filter: counter per channel. While sync == filt_level, it holds 0. While they differ, it increments each cycle. On the FILTER_LEN-th consecutive differing cycle, filt_level toggles and the counter returns to 0. A return to equality before that point resets the counter, and no toggle occurs.
- Detect: rise = filt_level 0→1, fall = 1→0. A channel qualifies if its mode selects that edge type. Mode 00 suppresses pulse, flag and count. The filter keeps running in all modes.
- edge_pulse[i] is registered and is high for exactly one cycle per qualifying toggle.
- edge_flag[i] is set on the same edge that asserts edge_pulse[i], and cleared while flag_clr[i] is high. Set and clear in the same cycle: set wins.
- event_count[i] increments on each qualifying toggle and saturates at all-ones (no wrap). cnt_clr with no event: count goes to 0. cnt_clr with an event in the same cycle: count goes to 1.
- mode is sampled on the cycle the toggle is detected. A mode change has no retroactive effect.

## Timing
- Let the first rising edge that samples the new input level be edge 1. filt_level changes after edge SYNC_STAGES+FILTER_LEN.
- edge_pulse, edge_flag and event_count update after edge SYNC_STAGES+FILTER_LEN+1. With the defaults, that is edge 6.
- Input pulses shorter than FILTER_LEN cycles at the sync output produce no output.
- Minimum spacing between two accepted edges on one channel is FILTER_LEN cycles.
- Back-to-back toggles produce separate pulses; pulses are never merged.
- Channels are fully independent. Simultaneous edges on several channels each produce their own pulse.
- Reset asserted mid-filter discards the partial count. No pulse is generated on reset release.

## Structure
- Package edge_det_pkg: mode constants MODE_OFF/MODE_RISE/MODE_FALL/MODE_BOTH (2-bit) and the filter counter width function clog2(FILTER_LEN+1).
- Sub-module edge_det_chan: one channel containing synchroniser, filter, detect, flag and counter. The top instantiates WIDTH copies with a generate loop and slices the buses.

## Test plan
Defaults, all modes = 11 unless stated.
- Reset: drive rst_n=0 with signal_in=4'hF and INIT_LEVEL=0, then release. filt_level must reach 4'hF after edge 5. A rise pulse fires on each channel once. With rst_n held low, all outputs stay 0.
- Latency: with mode[1:0]=10, drop signal_in[0] 1→0 (filt_level previously 1). edge_pulse[0] must be high for exactly one cycle after edge 6, and event_count[0]=1.
- Glitch: pulse signal_in[1] high for 2 cycles. filt_level[1], edge_pulse[1] and event_count[1] must stay 0. A 3-cycle pulse must yield one rise and one fall pulse.
- Modes: on channel 2, apply 3 rise/fall pairs under each of 00, 01, 10 and 11. Counts must be 0, 3, 3 and 6 respectively.
- Saturation and clear: with CNT_W=2, apply 5 edges and expect count 3. Assert cnt_clr on an event cycle and expect 1. Hold flag_clr[3] on a pulse cycle; edge_flag[3] must stay 1.
- Reset mid-operation: assert rst_n low 2 cycles into filtering. Outputs must go 0 and filt_level must go to INIT_LEVEL immediately. There must be no pulse after release until a full SYNC_STAGES+FILTER_LEN+1 sequence completes.
